stream_mux: RTL
===============

# stream_mux

Parametrised, registered N-to-1 datapath selector with valid/ready handshake on every channel, replacing the fixed-width, fixed-count combinational MUX family in the CPU datapath where sources become multi-cycle producers (e.g. memory, multiplier, CSR read). Supports explicit select and round-robin arbitration modes, registers the chosen word for one-cycle latency, and flags out-of-range selects instead of producing undefined output.

## Interface
- WIDTH, 32: data width per channel, ≥1
- N, 5: channel count, 2..16
- SEL_W, derived $clog2(N) (localparam, not overridable): select/source index width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- mode  in  1  0 = explicit select via `sel`, 1 = round-robin over valid channels
- sel  in  SEL_W  channel index in explicit mode; ignored in round-robin mode
- in_valid  in  N  per-channel data valid
- in_data  in  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel accept, one-hot or zero
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  registered selected word
- out_src  out  SEL_W  index of channel that produced out_data
- out_ready  in  1  downstream accept
- err_sel  out  1  one-cycle pulse: explicit-mode sel ≥ N while any in_valid bit set

## Operation
- Reset: out_valid=0, out_data=0, out_src=0, err_sel=0, round-robin pointer=0. Reset dominates all other events in the same cycle.
- can_accept = !out_valid || out_ready.
- Grant (combinational, same cycle): explicit mode: grant=sel if sel<N and in_valid[sel], else none. Round-robin: first i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N); none if in_valid==0.
- in_ready[g] = can_accept for granted g; all other bits 0. No in_ready asserted without a grant.
- Input transfer (in_valid[g] && in_ready[g]): out_data<=in_data[g], out_src<=g, out_valid<=1.
- Output transfer (out_valid && out_ready) with no input transfer: out_valid<=0; out_data/out_src hold.
- Simultaneous output and input transfer: register reloads; out_valid stays 1 (full throughput, one word/cycle).
- Round-robin pointer updates only on an input transfer in mode 1: ptr<=(g+1) mod N (wrap N-1→0). Unchanged in mode 0 and on stall.
- out_valid && !out_ready: out_data, out_src held stable; in_ready all 0.
- err_sel: registered, asserted cycle after mode=0 && sel≥N && |in_valid; no transfer occurs that cycle. Never asserted in mode 1.
- mode or sel may change any cycle; each beat is independent. Buffered word is unaffected by mode/sel changes.

## Timing
- Latency: input transfer at edge k → out_valid/out_data visible after edge k, consumable at edge k+1.
- Throughput: 1 word/cycle when out_ready held high.
- in_ready depends combinationally on in_valid, mode, sel, out_valid, out_ready; out_* and err_sel are registered only.
- Single-entry buffer: when full and stalled, backpressure reaches the granted channel in the same cycle.

## Structure
- Shared header/package `stream_mux_pkg`: MODE_SEL=1'b0, MODE_RR=1'b1 constants, channel-slice helper function.
- Sub-module `rr_arbiter` (N, SEL_W): in_valid, ptr → grant index + grant_valid; pointer register stays in stream_mux.
- Output register and handshake logic in stream_mux top.

## Test plan
- Reset mid-stream: out_valid=1, out_data=0xDEADBEEF, assert rst one cycle → out_valid=0, out_data=0, out_src=0, ptr=0 next cycle; in_ready=0 during rst.
- Explicit mode, N=5, sel=4, in_valid=5'b10000, in_data[4]=0x44, out_ready=1 → out_data=0x44, out_src=4 after one edge (regression for index 4 routing).
- Explicit mode, sel=5 (N=5), in_valid=5'b11111 → in_ready=0, err_sel pulses one cycle, out_valid stays 0.
- Round-robin, in_valid=5'b11111 constant, out_ready=1 → out_src sequence 0,1,2,3,4,0 on consecutive cycles, one word per cycle.
- Round-robin, ptr=3, in_valid=5'b00101 → grant 0 (wrap), ptr becomes 1; next grant 2.
- Backpressure: out_valid=1 with 0x11, out_ready=0 for 3 cycles while ch1 valid with 0x22 → out_data stays 0x11, in_ready=0; out_ready=1 → 0x11 consumed and 0x22 loaded same edge, out_valid remains 1.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux datapath selector:
// mode encoding and the channel-slice helper used for packed channel buses.
package stream_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // LSB position of channel idx inside a packed {ch[N-1], ..., ch[0]} bus.
    function automatic int unsigned chan_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Handshake bundle between N producers, the selector, and one consumer.
// The selector connects through the slave modport, the environment through master.
interface stream_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 5
);
    localparam int SEL_W = $clog2(N);

    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_src;
    logic                 out_ready;
    logic                 err_sel;

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, err_sel
    );

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, err_sel
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin grant search: first valid channel at or after i_ptr, wrapping mod N.
// Purely combinational; the pointer register lives in stream_mux.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N     = 5,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     i_valid,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_grant,
    output logic             o_grant_valid
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [SEL_W-1:0] w_off;
    logic             w_found;
    logic [SEL_W:0]   w_sum;

    // Rotate so bit 0 is the pointer position, pick the lowest set bit,
    // then map the offset back to an absolute channel index.
    always_comb begin
        w_dbl   = {i_valid, i_valid} >> i_ptr;
        w_rot   = w_dbl[N-1:0];
        w_off   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_off   = SEL_W'(k);
                w_found = 1'b1;
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= N_EXT) begin
            w_sum = w_sum - N_EXT;
        end
    end

    assign o_grant       = w_sum[SEL_W-1:0];
    assign o_grant_valid = w_found;

endmodule

// File: rtl/stream_mux.sv
// Registered N-to-1 stream selector with explicit-select and round-robin modes,
// single-entry output buffer, and a registered flag for out-of-range selects.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 5
) (
    input  logic       clk,
    input  logic       rst,
    stream_mux_if.slave bus
);

    localparam int             SEL_W = $clog2(N);
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_data;
    logic [SEL_W-1:0]       r_out_src;
    logic                   r_err_sel;
    logic [SEL_W-1:0]       r_ptr;

    logic                   w_can_accept;
    logic                   w_sel_in_range;
    logic [(1<<SEL_W)-1:0]  w_valid_pad;
    logic                   w_sel_hit;
    logic [SEL_W-1:0]       w_rr_grant;
    logic                   w_rr_valid;
    logic [SEL_W-1:0]       w_grant;
    logic                   w_grant_valid;
    logic                   w_take;
    logic                   w_err;
    logic [WIDTH-1:0]       w_sel_data;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .i_valid       (bus.in_valid),
        .i_ptr         (r_ptr),
        .o_grant       (w_rr_grant),
        .o_grant_valid (w_rr_valid)
    );

    assign w_can_accept   = !r_out_valid || bus.out_ready;
    assign w_sel_in_range = {1'b0, bus.sel} < N_EXT;
    assign w_err          = (bus.mode == MODE_SEL) && !w_sel_in_range && (|bus.in_valid);

    // Padding in_valid to a power of two keeps an out-of-range sel index defined.
    always_comb begin
        w_valid_pad          = '0;
        w_valid_pad[N-1:0]   = bus.in_valid;
        w_sel_hit            = w_sel_in_range && w_valid_pad[bus.sel];
    end

    always_comb begin
        if (bus.mode == MODE_RR) begin
            w_grant       = w_rr_grant;
            w_grant_valid = w_rr_valid;
        end else begin
            w_grant       = bus.sel;
            w_grant_valid = w_sel_hit;
        end
    end

    assign w_take = w_grant_valid && w_can_accept && !rst;

    always_comb begin
        bus.in_ready = '0;
        if (w_take) begin
            bus.in_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_sel_data = bus.in_data[chan_lsb(i, WIDTH) +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_err_sel   <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_err_sel <= w_err;
            if (w_take) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_src   <= w_grant;
                if (bus.mode == MODE_RR) begin
                    r_ptr <= (w_grant == SEL_W'(N-1)) ? '0 : w_grant + 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign bus.err_sel   = r_err_sel;

endmodule
